// File: rtl/mmcm_drp_pkg.sv
// Shared definitions for the MMCM/PLL DRP initiator and responder.
// Contents: DRP register address map constants and the responder FSM state enum.
package mmcm_drp_pkg;

    localparam logic [6:0] CLKOUT0_REG1  = 7'h08;
    localparam logic [6:0] CLKOUT0_REG2  = 7'h09;
    localparam logic [6:0] CLKFBOUT_REG1 = 7'h14;
    localparam logic [6:0] CLKFBOUT_REG2 = 7'h15;
    localparam logic [6:0] DIVCLK_REG    = 7'h16;
    localparam logic [6:0] LOCK_REG1     = 7'h18;
    localparam logic [6:0] LOCK_REG2     = 7'h19;
    localparam logic [6:0] LOCK_REG3     = 7'h1A;
    localparam logic [6:0] POWER_REG     = 7'h28;
    localparam logic [6:0] FILT_REG1     = 7'h4E;
    localparam logic [6:0] FILT_REG2     = 7'h4F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } drp_state_t;

endpackage

// File: rtl/mmcm_lock_model.sv
// LOCKED model for the MMCM/PLL primitive.
// Ports:
//   dclk     - clock
//   rst_n    - asynchronous active-low reset
//   rst_mmcm - modelled primitive RST (active-high); holds the lock counter at 0
//   restart  - one-cycle strobe that drops locked and restarts the lock count
//   locked   - high once LOCK_DELAY cycles have elapsed since RST/restart released
module mmcm_lock_model #(
    parameter int unsigned LOCK_DELAY = 64
) (
    input  logic dclk,
    input  logic rst_n,
    input  logic rst_mmcm,
    input  logic restart,
    output logic locked
);

    localparam logic [15:0] LOCK_TARGET = 16'(LOCK_DELAY);

    logic [15:0] lock_cnt;

    // Counter saturates at the target, so locked is simply "target reached".
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
        end else if (rst_mmcm || restart) begin
            lock_cnt <= '0;
        end else if (lock_cnt != LOCK_TARGET) begin
            lock_cnt <= lock_cnt + 16'd1;
        end
    end

    assign locked = (lock_cnt == LOCK_TARGET);

endmodule

// File: rtl/mmcm_drp_responder.sv
// Responder side of the MMCME2/PLLE2 DRP port: 128 x 16 register image,
// DRDY after DRDY_LATENCY dclk cycles, and a LOCKED model around rst_mmcm.
// Optional feature macro: MMCM_DRP_WRITE_GUARD_EN (a write accepted while
// rst_mmcm=0 sets err and restarts the lock sequence).
// Ports:
//   dclk, rst_n          - clock, asynchronous active-low reset
//   den, dwe, daddr, din - DRP request (sampled together with den)
//   dout, drdy           - response; dout is zero outside the drdy cycle
//   rst_mmcm, locked     - modelled primitive RST and LOCKED
//   err                  - sticky protocol-error flag
//   wr_count             - completed-write counter (wraps)
import mmcm_drp_pkg::*;

module mmcm_drp_responder #(
    parameter int unsigned DRDY_LATENCY = 4,
    parameter int unsigned LOCK_DELAY   = 64,
    parameter int unsigned ADDR_W       = 7
) (
    input  logic              dclk,
    input  logic              rst_n,
    input  logic              den,
    input  logic              dwe,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [15:0]       din,
    output logic [15:0]       dout,
    output logic              drdy,
    input  logic              rst_mmcm,
    output logic              locked,
    output logic              err,
    output logic [7:0]        wr_count
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  LAT_LOAD = 4'(DRDY_LATENCY - 1);

    drp_state_t        state, state_next;
    logic [3:0]        lat_cnt, lat_cnt_next;
    logic              accept;
    logic              bad_den;
    logic              restart;
    logic [ADDR_W-1:0] lat_addr;
    logic [15:0]       lat_din;
    logic              lat_we;
    logic [15:0]       image [DEPTH];

    // A den in the RESP cycle is accepted: the FSM is back in IDLE at that
    // edge, which gives gap-free back-to-back transactions. Only BUSY rejects.
    always_comb begin
        state_next   = state;
        lat_cnt_next = lat_cnt;
        accept       = 1'b0;
        bad_den      = 1'b0;
        case (state)
            IDLE: begin
                accept = den;
            end
            BUSY: begin
                lat_cnt_next = lat_cnt - 4'd1;
                bad_den      = den;
                // Leave when the counter reaches zero on this edge.
                if (lat_cnt <= 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
                accept     = den;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (accept) begin
            lat_cnt_next = LAT_LOAD;
            state_next   = (DRDY_LATENCY == 1) ? RESP : BUSY;
        end
    end

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_next;
            lat_cnt <= lat_cnt_next;
        end
    end

`ifdef MMCM_DRP_WRITE_GUARD_EN
    assign restart = accept & dwe & ~rst_mmcm;
`else
    assign restart = 1'b0;
`endif

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr <= '0;
            lat_din  <= '0;
            lat_we   <= 1'b0;
            err      <= 1'b0;
            wr_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                image[i] <= '0;
            end
        end else begin
            if (accept) begin
                lat_addr <= daddr;
                lat_din  <= din;
                lat_we   <= dwe;
            end
            if (bad_den || restart) begin
                err <= 1'b1;
            end
            if (state == RESP && lat_we) begin
                image[lat_addr] <= lat_din;
                wr_count        <= wr_count + 8'd1;
            end
        end
    end

    assign drdy = (state == RESP);
    assign dout = (drdy && !lat_we) ? image[lat_addr] : '0;

    mmcm_lock_model #(
        .LOCK_DELAY(LOCK_DELAY)
    ) u_lock (
        .dclk    (dclk),
        .rst_n   (rst_n),
        .rst_mmcm(rst_mmcm),
        .restart (restart),
        .locked  (locked)
    );

endmodule

// File: tb/tb_mmcm_drp_responder.sv
// Self-checking bench for mmcm_drp_responder (DRDY_LATENCY=4, LOCK_DELAY=64).
// Honours MMCM_DRP_WRITE_GUARD_EN when defined for the build.
module tb_mmcm_drp_responder;
    import mmcm_drp_pkg::*;

    localparam int unsigned LAT   = 4;
    localparam int unsigned LOCKD = 64;
`ifdef MMCM_DRP_WRITE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        dclk;
    logic        rst_n;
    logic        den;
    logic        dwe;
    logic [6:0]  daddr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        drdy;
    logic        rst_mmcm;
    logic        locked;
    logic        err;
    logic [7:0]  wr_count;

    mmcm_drp_responder #(
        .DRDY_LATENCY(LAT),
        .LOCK_DELAY  (LOCKD),
        .ADDR_W      (7)
    ) dut (
        .dclk    (dclk),
        .rst_n   (rst_n),
        .den     (den),
        .dwe     (dwe),
        .daddr   (daddr),
        .din     (din),
        .dout    (dout),
        .drdy    (drdy),
        .rst_mmcm(rst_mmcm),
        .locked  (locked),
        .err     (err),
        .wr_count(wr_count)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    int checks   = 0;
    int failures = 0;
    int stray_dout = 0;

    // Reference model: register image, write count and sticky error.
    logic [15:0] ref_img [128];
    logic [7:0]  ref_wrc;
    logic        ref_err;

    always @(negedge dclk) begin
        if (rst_n && !drdy && dout != 16'h0) stray_dout++;
    end

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_dout;
        logic [7:0]  exp_wrc;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) ref_img[i] = 16'h0;
        ref_wrc = 8'h0;
        ref_err = 1'b0;
    endtask

    // Model outcome of one transaction; returns the expected dout.
    task automatic model_txn(input logic we, input logic [6:0] a, input logic [15:0] d,
                             output logic [15:0] exp);
        if (we) begin
            ref_img[a] = d;
            ref_wrc    = ref_wrc + 8'd1;
            exp        = 16'h0;
        end else begin
            exp = ref_img[a];
        end
    endtask

    // Called just after a posedge; returns dout at drdy and the cycle count
    // from den to drdy (-1 on timeout). Also checks drdy is a single pulse.
    task automatic do_txn(input logic we, input logic [6:0] a, input logic [15:0] d,
                          output logic [15:0] got, output int lat);
        den = 1'b1; dwe = we; daddr = a; din = d;
        tick();
        den = 1'b0; dwe = 1'b0;
        lat = -1;
        got = 16'h0;
        for (int k = 1; k <= 20; k++) begin
            if (drdy) begin
                lat = k;
                got = dout;
                break;
            end
            tick();
        end
        if (lat > 0) begin
            tick();
            chk("drdy single pulse", 32'(drdy), 32'd0);
        end
    endtask

    task automatic txn_check(input string tag, input logic we, input logic [6:0] a,
                             input logic [15:0] d);
        logic [15:0] exp, got;
        int lat;
        model_txn(we, a, d, exp);
        do_txn(we, a, d, got, lat);
        chk($sformatf("%s latency", tag), 32'(lat), 32'(LAT));
        chk($sformatf("%s dout", tag), 32'(got), 32'(exp));
        chk($sformatf("%s wr_count", tag), 32'(wr_count), 32'(ref_wrc));
    endtask

    logic [6:0] addrs [11];

    initial begin
        logic [15:0] got, exp;
        int lat, pulses, first, n, resp_idx;
        logic        bwe  [6];
        logic [6:0]  badr [6];
        logic [15:0] bdat [6];
        logic [15:0] bexp [6];
        int last_drdy;

        addrs = '{CLKOUT0_REG1, CLKOUT0_REG2, CLKFBOUT_REG1, CLKFBOUT_REG2, DIVCLK_REG,
                  LOCK_REG1, LOCK_REG2, LOCK_REG3, POWER_REG, FILT_REG1, FILT_REG2};
        tbl[0] = '{1'b1, CLKOUT0_REG1, 16'h028A, 16'h0000, 8'd1};
        tbl[1] = '{1'b0, CLKOUT0_REG1, 16'h0000, 16'h028A, 8'd1};
        tbl[2] = '{1'b1, FILT_REG1,    16'h1234, 16'h0000, 8'd2};
        tbl[3] = '{1'b0, FILT_REG1,    16'h0000, 16'h1234, 8'd2};
        tbl[4] = '{1'b1, FILT_REG1,    16'hABCD, 16'h0000, 8'd3};
        tbl[5] = '{1'b0, FILT_REG1,    16'h0000, 16'hABCD, 8'd3};
        tbl[6] = '{1'b0, CLKOUT0_REG2, 16'h0000, 16'h0000, 8'd3};
        tbl[7] = '{1'b1, POWER_REG,    16'hFFFF, 16'h0000, 8'd4};
        tbl[8] = '{1'b0, POWER_REG,    16'h0000, 16'hFFFF, 8'd4};

        model_reset();
        rst_n = 1'b0; den = 1'b0; dwe = 1'b0; daddr = '0; din = '0; rst_mmcm = 1'b1;
        #23;
        chk("reset dout", 32'(dout), 32'd0);
        chk("reset drdy", 32'(drdy), 32'd0);
        chk("reset locked", 32'(locked), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset wr_count", 32'(wr_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Directed table (rst_mmcm held high: DRP must work during primitive reset).
        for (int i = 0; i < 9; i++) begin
            model_txn(tbl[i].we, tbl[i].addr, tbl[i].data, exp);
            do_txn(tbl[i].we, tbl[i].addr, tbl[i].data, got, lat);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(LAT));
            chk($sformatf("vec%0d dout", i), 32'(got), 32'(tbl[i].exp_dout));
            chk($sformatf("vec%0d wr_count", i), 32'(wr_count), 32'(tbl[i].exp_wrc));
        end
        chk("table err", 32'(err), 32'd0);

        // Randomised transactions against the model.
        for (int i = 0; i < 40; i++) begin
            logic        we;
            logic [6:0]  a;
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) a = addrs[$urandom_range(0, 10)];
            else a = 7'($urandom_range(0, 127));
            txn_check($sformatf("rand%0d", i), we, a, 16'($urandom));
        end
        chk("random err", 32'(err), 32'd0);

        // Back-to-back: den in each drdy cycle, 3 writes then 3 reads.
        for (int i = 0; i < 6; i++) begin
            bwe[i]  = (i < 3);
            badr[i] = (i % 3 == 0) ? CLKFBOUT_REG1 : ((i % 3 == 1) ? CLKFBOUT_REG2 : DIVCLK_REG);
            bdat[i] = 16'($urandom);
        end
        begin
            logic [7:0] wrc0;
            wrc0 = ref_wrc;
            for (int i = 0; i < 6; i++) model_txn(bwe[i], badr[i], bdat[i], bexp[i]);
            den = 1'b1; dwe = bwe[0]; daddr = badr[0]; din = bdat[0];
            resp_idx = 0; last_drdy = 0;
            for (int cyc = 1; cyc <= 60 && resp_idx < 6; cyc++) begin
                tick();
                den = 1'b0; dwe = 1'b0;
                if (drdy) begin
                    chk($sformatf("b2b%0d gap", resp_idx), 32'(cyc - last_drdy), 32'(LAT));
                    chk($sformatf("b2b%0d dout", resp_idx), 32'(dout), 32'(bexp[resp_idx]));
                    last_drdy = cyc;
                    resp_idx++;
                    if (resp_idx < 6) begin
                        den = 1'b1; dwe = bwe[resp_idx]; daddr = badr[resp_idx]; din = bdat[resp_idx];
                    end
                end
            end
            chk("b2b responses", 32'(resp_idx), 32'd6);
            tick();
            chk("b2b wr_count", 32'(wr_count - wrc0), 32'd3);
            chk("b2b err", 32'(err), 32'd0);
        end

        // Lock sequence.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("locked in rst_mmcm", 32'(locked), 32'd0);
        end
        rst_mmcm = 1'b0;
        for (n = 1; n <= 70; n++) begin
            tick();
            chk($sformatf("lock n=%0d", n), 32'(locked), 32'(n >= int'(LOCKD)));
        end
        rst_mmcm = 1'b1;
        chk("locked before drop edge", 32'(locked), 32'd1);
        tick();
        chk("locked drop", 32'(locked), 32'd0);

        // Write while locked: guard behaviour depends on build.
        rst_mmcm = 1'b0;
        repeat (LOCKD) tick();
        chk("relock before guard", 32'(locked), 32'd1);
        model_txn(1'b1, POWER_REG, 16'h5A5A, exp);
        if (GUARD) ref_err = 1'b1;
        den = 1'b1; dwe = 1'b1; daddr = POWER_REG; din = 16'h5A5A;
        lat = -1;
        for (n = 0; n <= 70; n++) begin
            tick();
            den = 1'b0; dwe = 1'b0;
            if (drdy) lat = n + 1;
            chk($sformatf("guard locked n=%0d", n), 32'(locked),
                32'(GUARD ? (n >= int'(LOCKD)) : 1));
        end
        chk("guard latency", 32'(lat), 32'(LAT));
        chk("guard err", 32'(err), 32'(ref_err));
        chk("guard wr_count", 32'(wr_count), 32'(ref_wrc));
        rst_mmcm = 1'b1;
        tick();
        txn_check("guard readback", 1'b0, POWER_REG, 16'h0);

        // den two cycles into BUSY: rejected, err sticky, single drdy.
        den = 1'b1; dwe = 1'b0; daddr = CLKOUT0_REG1; din = 16'h0;
        tick();
        den = 1'b0;
        tick();
        den = 1'b1; dwe = 1'b1; daddr = 7'h30; din = 16'hBEEF;
        tick();
        den = 1'b0; dwe = 1'b0;
        pulses = 0; first = -1; got = 16'h0;
        for (int j = 3; j <= 12; j++) begin
            if (drdy) begin
                pulses++;
                if (first < 0) begin first = j; got = dout; end
            end
            tick();
        end
        ref_err = 1'b1;
        chk("busy den pulses", 32'(pulses), 32'd1);
        chk("busy den latency", 32'(first), 32'(LAT));
        chk("busy den dout", 32'(got), 32'(ref_img[CLKOUT0_REG1]));
        chk("busy den err", 32'(err), 32'd1);
        txn_check("ignored write addr", 1'b0, 7'h30, 16'h0);
        chk("err sticky", 32'(err), 32'd1);

        // wr_count wrap, exercising the top address.
        while (ref_wrc != 8'hFF) begin
            model_txn(1'b1, 7'h7F, 16'($urandom), exp);
            do_txn(1'b1, 7'h7F, ref_img[7'h7F], got, lat);
        end
        chk("wr_count ff", 32'(wr_count), 32'hFF);
        txn_check("wrap write", 1'b1, 7'h7F, 16'h8001);
        chk("wr_count wrapped", 32'(wr_count), 32'h00);
        txn_check("top addr read", 1'b0, 7'h7F, 16'h0);

        // rst_n pulsed in BUSY of a write to FILT_REG1.
        den = 1'b1; dwe = 1'b1; daddr = FILT_REG1; din = 16'hFFFF;
        tick();
        den = 1'b0; dwe = 1'b0;
        tick();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("midrst err", 32'(err), 32'd0);
        chk("midrst wr_count", 32'(wr_count), 32'd0);
        chk("midrst drdy", 32'(drdy), 32'd0);
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int j = 0; j < 8; j++) begin
            if (drdy) pulses++;
            tick();
        end
        chk("midrst no drdy", 32'(pulses), 32'd0);
        txn_check("midrst read filt", 1'b0, FILT_REG1, 16'h0);
        txn_check("midrst read clkout", 1'b0, CLKOUT0_REG1, 16'h0);
        chk("midrst err after", 32'(err), 32'd0);

        chk("dout zero outside drdy", 32'(stray_dout), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
